// File: rtl/line_buffer_ctrl.sv
// Ping-pong controller for two sprite line-buffer SRAM banks (write bank / scanout bank).
// Optional per-pixel erase after scanout: define LINE_BUFFER_CTRL_ERASE_EN.
module line_buffer_ctrl #(
    parameter int unsigned   AW      = 9,
    parameter int unsigned   DW      = 8,
    parameter logic [DW-1:0] CLR_VAL = 8'hFF
) (
    input  logic          clk,
    input  logic          VIDEO_RST,
    input  logic          line_toggle,
    input  logic          wr_cen,
    input  logic          wr_load,
    input  logic [AW-1:0] wr_x,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_pix,
    input  logic          rd_cen,
    input  logic          rd_load,
    input  logic [AW-1:0] rd_start,
    input  logic          rd_up,
    output logic          bank_sel,
    output logic [AW-1:0] b0_addr,
    output logic [AW-1:0] b1_addr,
    output logic          b0_we,
    output logic          b1_we,
    output logic [DW-1:0] b0_wdata,
    output logic [DW-1:0] b1_wdata,
    input  logic [DW-1:0] b0_rdata,
    input  logic [DW-1:0] b1_rdata,
    output logic [DW-1:0] pix_out,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1
    } state_t;

    state_t        r_state;
    logic          r_bank_sel;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_rd_addr;
    logic          r_rd_pend;
    logic          r_rd_bank;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_pix;

    logic          w_active;
    logic          w_sel;
    logic          w_wr_slot;
    logic          w_rd_slot;
    logic          w_opaque;
    logic          w_wr_we;
    logic          w_er_we;
    logic [AW-1:0] w_rd_bank_addr;
    logic [DW-1:0] w_rdata;

    // A toggle in this clk already counts: the swap takes effect before any write or load.
    assign w_active  = !VIDEO_RST && ((r_state == StRun) || line_toggle);
    assign w_sel     = r_bank_sel ^ line_toggle;
    assign w_wr_slot = w_active && wr_cen;
    assign w_rd_slot = w_active && rd_cen;
    assign w_opaque  = (wr_pix[2:0] != 3'b111);
    assign w_wr_we   = w_wr_slot && !wr_load && wr_valid && w_opaque;
    assign w_rdata   = r_rd_bank ? b1_rdata : b0_rdata;

`ifdef LINE_BUFFER_CTRL_ERASE_EN
    logic [AW-1:0] r_er_addr;

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            r_er_addr <= '0;
        end else if (w_rd_slot) begin
            r_er_addr <= r_rd_addr;
        end
    end

    // A swap between the read and its erase hands that bank to the writer, so the erase is dropped.
    assign w_er_we        = r_rd_pend && !line_toggle && !VIDEO_RST;
    assign w_rd_bank_addr = w_er_we ? r_er_addr : r_rd_addr;
`else
    assign w_er_we        = 1'b0;
    assign w_rd_bank_addr = r_rd_addr;
`endif

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            r_state    <= StIdle;
            r_bank_sel <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (line_toggle) begin
                        r_state    <= StRun;
                        r_bank_sel <= ~r_bank_sel;
                    end
                end
                StRun: begin
                    if (line_toggle) begin
                        r_bank_sel <= ~r_bank_sel;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_bank_sel <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            r_wr_addr <= '0;
        end else if (w_wr_slot) begin
            if (wr_load) begin
                r_wr_addr <= wr_x;
            end else if (wr_valid) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // The address held on a rd_cen clk is the one read; data lands one clk later in r_rd_data
    // and reaches pix_out on the following rd_cen.
    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            r_rd_addr <= '0;
            r_rd_pend <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_data <= CLR_VAL;
            r_pix     <= CLR_VAL;
        end else begin
            r_rd_pend <= w_rd_slot;
            if (w_rd_slot) begin
                r_rd_bank <= ~w_sel;
                r_pix     <= r_rd_data;
                if (rd_load) begin
                    r_rd_addr <= rd_start;
                end else if (rd_up) begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end else begin
                    r_rd_addr <= r_rd_addr - 1'b1;
                end
            end
            if (r_rd_pend) begin
                r_rd_data <= w_rdata;
            end
        end
    end

    assign bank_sel = r_bank_sel;
    assign state    = r_state;
    assign pix_out  = r_pix;

    assign b0_addr  = w_sel ? w_rd_bank_addr : r_wr_addr;
    assign b1_addr  = w_sel ? r_wr_addr : w_rd_bank_addr;
    assign b0_we    = w_sel ? w_er_we : w_wr_we;
    assign b1_we    = w_sel ? w_wr_we : w_er_we;
    assign b0_wdata = w_sel ? CLR_VAL : wr_pix;
    assign b1_wdata = w_sel ? wr_pix : CLR_VAL;

    rd_cen_spacing : assert property (@(posedge clk) disable iff (VIDEO_RST) rd_cen |=> !rd_cen);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: two SRAM bank models, a reference line-buffer model checked
// every cycle, and directed scenarios with literal expectations.
module tb_line_buffer_ctrl;

    logic       clk = 1'b0;
    logic       VIDEO_RST = 1'b1;
    logic       line_toggle = 1'b0;
    logic       wr_cen = 1'b0, wr_load = 1'b0, wr_valid = 1'b0;
    logic [8:0] wr_x = '0;
    logic [7:0] wr_pix = '0;
    logic       rd_cen = 1'b0, rd_load = 1'b0, rd_up = 1'b1;
    logic [8:0] rd_start = '0;
    logic       bank_sel, b0_we, b1_we;
    logic [8:0] b0_addr, b1_addr;
    logic [7:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata, pix_out;
    logic [1:0] state;

    int n_checks = 0;
    int n_err    = 0;

    line_buffer_ctrl dut (
        .clk(clk), .VIDEO_RST(VIDEO_RST), .line_toggle(line_toggle),
        .wr_cen(wr_cen), .wr_load(wr_load), .wr_x(wr_x), .wr_valid(wr_valid), .wr_pix(wr_pix),
        .rd_cen(rd_cen), .rd_load(rd_load), .rd_start(rd_start), .rd_up(rd_up),
        .bank_sel(bank_sel), .b0_addr(b0_addr), .b1_addr(b1_addr), .b0_we(b0_we),
        .b1_we(b1_we), .b0_wdata(b0_wdata), .b1_wdata(b1_wdata), .b0_rdata(b0_rdata),
        .b1_rdata(b1_rdata), .pix_out(pix_out), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // SRAM bank models: synchronous read, one clk latency, read-before-write.
    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];
    always @(posedge clk) begin
        if (VIDEO_RST) begin
            for (int i = 0; i < 512; i++) begin
                mem0[i] = init_val(i);
                mem1[i] = init_val(i);
            end
        end
        b0_rdata <= mem0[b0_addr];
        b1_rdata <= mem1[b1_addr];
        if (b0_we) mem0[b0_addr] = b0_wdata;
        if (b1_we) mem1[b1_addr] = b1_wdata;
    end

    // Reference model: bank contents plus the controller's architectural counters.
    logic [7:0] ref_mem [2][512];
    bit         m_ok = 0, m_run, m_sel, m_er_pend;
    int         m_wa, m_ra, m_er_addr;
    logic [7:0] m_pix, m_stage;

    always @(posedge clk) begin : model
        bit act, esel;
        if (VIDEO_RST) begin
            for (int i = 0; i < 512; i++) begin
                ref_mem[0][i] = init_val(i);
                ref_mem[1][i] = init_val(i);
            end
            m_ok = 1; m_run = 0; m_sel = 0; m_wa = 0; m_ra = 0; m_er_pend = 0;
            m_pix = 8'hFF; m_stage = 8'hFF;
        end else begin
            act  = m_run || line_toggle;
            esel = m_sel ^ line_toggle;
`ifdef LINE_BUFFER_CTRL_ERASE_EN
            if (m_er_pend && !line_toggle) ref_mem[!esel][m_er_addr] = 8'hFF;
`endif
            m_er_pend = 0;
            if (act && wr_cen) begin
                if (wr_load) m_wa = int'(wr_x);
                else if (wr_valid) begin
                    if (wr_pix[2:0] != 3'b111) ref_mem[esel][m_wa] = wr_pix;
                    m_wa = (m_wa + 1) % 512;
                end
            end
            if (act && rd_cen) begin
                m_pix     = m_stage;
                m_stage   = ref_mem[!esel][m_ra];
                m_er_pend = 1;
                m_er_addr = m_ra;
                if (rd_load) m_ra = int'(rd_start);
                else m_ra = rd_up ? (m_ra + 1) % 512 : (m_ra + 511) % 512;
            end
            m_sel = esel;
            if (line_toggle) m_run = 1;
        end
    end

    always @(negedge clk) begin : compare
        bit act, esel;
        bit ew [2];
        int ea [2];
        logic [7:0] ed [2];
        if (m_ok) begin
            act  = !VIDEO_RST && (m_run || line_toggle);
            esel = m_sel ^ line_toggle;
            ew[0] = 0; ew[1] = 0; ea[0] = 0; ea[1] = 0; ed[0] = 0; ed[1] = 0;
            if (act && wr_cen && !wr_load && wr_valid && wr_pix[2:0] != 3'b111) begin
                ew[esel] = 1; ea[esel] = m_wa; ed[esel] = wr_pix;
            end
`ifdef LINE_BUFFER_CTRL_ERASE_EN
            if (!VIDEO_RST && m_er_pend && !line_toggle) begin
                ew[!esel] = 1; ea[!esel] = m_er_addr; ed[!esel] = 8'hFF;
            end
`endif
            chk("b0_we", 32'(b0_we), 32'(ew[0]));
            chk("b1_we", 32'(b1_we), 32'(ew[1]));
            if (ew[0]) begin
                chk("b0_addr", 32'(b0_addr), ea[0]);
                chk("b0_wdata", 32'(b0_wdata), 32'(ed[0]));
            end
            if (ew[1]) begin
                chk("b1_addr", 32'(b1_addr), ea[1]);
                chk("b1_wdata", 32'(b1_wdata), 32'(ed[1]));
            end
            chk("wr_bank_addr", 32'(esel ? b1_addr : b0_addr), m_wa);
            if (act && rd_cen) chk("rd_bank_addr", 32'(esel ? b0_addr : b1_addr), m_ra);
            chk("state", 32'(state), 32'(m_run));
            chk("bank_sel", 32'(bank_sel), 32'(m_sel));
            chk("pix_out", 32'(pix_out), 32'(m_pix));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        line_toggle = 1'b1;
        cyc();
        line_toggle = 1'b0;
    endtask

    task automatic wr_slot(input logic load, input logic [8:0] x, input logic valid,
                           input logic [7:0] pix);
        wr_cen = 1'b1; wr_load = load; wr_x = x; wr_valid = valid; wr_pix = pix;
        cyc();
        wr_cen = 1'b0; wr_load = 1'b0; wr_valid = 1'b0;
    endtask

    // One rd_cen followed by three quiet clks; returns the read-bank address presented.
    task automatic rd_slot(input logic load, input logic [8:0] start, input logic up,
                           output logic [8:0] seen);
        rd_cen = 1'b1; rd_load = load; rd_start = start; rd_up = up;
        #2 seen = bank_sel ? b0_addr : b1_addr;
        cyc();
        rd_cen = 1'b0; rd_load = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [8:0] seen;
        logic [8:0] exp_dec [4];
        exp_dec[0] = 9'd1; exp_dec[1] = 9'd0; exp_dec[2] = 9'd511; exp_dec[3] = 9'd510;

        repeat (3) begin
            cyc();
            chk("rst_b0_we", 32'(b0_we), 0);
            chk("rst_b1_we", 32'(b1_we), 0);
            chk("rst_state", 32'(state), 0);
            chk("rst_pix", 32'(pix_out), 32'h0FF);
        end
        VIDEO_RST = 1'b0;
        cyc();
        toggle();
        chk("run_state", 32'(state), 1);
        chk("run_bank_sel", 32'(bank_sel), 1);
        chk("run_pix", 32'(pix_out), 32'h0FF);

        // Write path into bank1, one transparent pixel in the middle.
        wr_slot(1'b1, 9'd10, 1'b1, 8'h00);
        wr_slot(1'b0, 9'd0, 1'b1, 8'h21);
        wr_slot(1'b0, 9'd0, 1'b1, 8'h07);
        wr_slot(1'b0, 9'd0, 1'b1, 8'h35);
        cyc();
        chk("mem1_10", 32'(mem1[10]), 32'h21);
        chk("mem1_11", 32'(mem1[11]), 32'h51);
        chk("mem1_12", 32'(mem1[12]), 32'h35);
        chk("wr_addr_end", 32'(b1_addr), 13);

        // Scanout of bank1, incrementing.
        toggle();
        rd_slot(1'b1, 9'd10, 1'b1, seen);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        chk("rd_pix_10", 32'(pix_out), 32'h21);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        chk("rd_pix_11", 32'(pix_out), 32'h51);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        chk("rd_pix_12", 32'(pix_out), 32'h35);

        // Re-read the same bank: blank after erase, stale otherwise.
        rd_slot(1'b1, 9'd10, 1'b1, seen);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
`ifdef LINE_BUFFER_CTRL_ERASE_EN
        chk("reread_10", 32'(pix_out), 32'h0FF);
`else
        chk("reread_10", 32'(pix_out), 32'h21);
`endif
        rd_slot(1'b0, 9'd0, 1'b1, seen);
        rd_slot(1'b0, 9'd0, 1'b1, seen);
`ifdef LINE_BUFFER_CTRL_ERASE_EN
        chk("reread_12", 32'(pix_out), 32'h0FF);
`else
        chk("reread_12", 32'(pix_out), 32'h35);
`endif

        // Decrementing read wraps 0 -> 511.
        rd_slot(1'b1, 9'd1, 1'b0, seen);
        for (int i = 0; i < 4; i++) begin
            rd_slot(1'b0, 9'd0, 1'b0, seen);
            chk("dec_addr", 32'(seen), 32'(exp_dec[i]));
        end

        // Write wrap into bank0.
        wr_slot(1'b1, 9'd511, 1'b1, 8'h00);
        wr_slot(1'b0, 9'd0, 1'b1, 8'h40);
        wr_slot(1'b0, 9'd0, 1'b1, 8'h50);
        cyc();
        chk("wrap_511", 32'(mem0[511]), 32'h40);
        chk("wrap_0", 32'(mem0[0]), 32'h50);

        // Toggle and write in the same clk: write lands in the new write bank.
        line_toggle = 1'b1;
        wr_slot(1'b0, 9'd0, 1'b1, 8'h66);
        line_toggle = 1'b0;
        cyc();
        chk("tog_bank_sel", 32'(bank_sel), 1);
        chk("tog_mem1_1", 32'(mem1[1]), 32'h66);
        chk("tog_mem0_1", 32'(mem0[1]), 32'h5B);

        // Read immediately followed by a swap; any pending erase must not hit the new write bank.
        rd_cen = 1'b1;
        cyc();
        rd_cen = 1'b0;
        toggle();
        repeat (3) cyc();

        // Mid-run reset.
        VIDEO_RST = 1'b1;
        repeat (2) cyc();
        chk("rst2_state", 32'(state), 0);
        chk("rst2_bank_sel", 32'(bank_sel), 0);
        chk("rst2_pix", 32'(pix_out), 32'h0FF);
        VIDEO_RST = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
